// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   PC_RESET_VALUE : address the PC register loads while reset is low
//   DATA_W         : instruction word width
//   PS_*           : PC select encodings driven on ps
//   fetch_state_e  : sequencer state encoding
//   redir_ps()     : PC select for a redirect (absolute load or word-relative)
package fetch_sequencer_pkg;

    localparam logic [31:0] PC_RESET_VALUE = 32'h8000_0000;
    localparam int          DATA_W         = 32;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b11;
    localparam logic [1:0] PS_REL  = 2'b10;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [1:0] redir_ps(input logic jump);
        return jump ? PS_LOAD : PS_REL;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its neighbours (PC register,
// instruction memory, execute redirect port and decode).
//   master : the fetch sequencer side
//   slave  : the environment side (PC, imem, execute, decode)
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic [31:0]       pc_q;
    logic [1:0]        ps;
    logic [29:0]       pc_in;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              redir_valid;
    logic              redir_jump;
    logic [29:0]       redir_val;
    logic [DATA_W-1:0] ir;
    logic [31:0]       ir_pc;
    logic              ir_valid;
    logic              ir_ready;

    modport master (
        input  pc_q, imem_ack, imem_rdata, redir_valid, redir_jump, redir_val, ir_ready,
        output ps, pc_in, imem_req, imem_addr, ir, ir_pc, ir_valid
    );

    modport slave (
        output pc_q, imem_ack, imem_rdata, redir_valid, redir_jump, redir_val, ir_ready,
        input  ps, pc_in, imem_req, imem_addr, ir, ir_pc, ir_valid
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the PC register through ps/pc_in,
// issues one instruction-memory read per PC value, keeps the fetched word in
// a one-entry IR buffer for decode and applies jump/branch redirects.
//   clock : rising-edge clock
//   reset : synchronous, active low
//   bus   : fetch_sequencer_if.master (PC control, imem read, redirect, IR)
//
// state   | meaning
// S_BOOT  | first cycle after reset, PC settling on its reset value
// S_FETCH | request when the IR buffer is empty, otherwise wait for decode
// S_DRAIN | redirect hit an outstanding read; wait for its ack, then redirect
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    fetch_state_e      state_q;
    logic [DATA_W-1:0] ir_q;
    logic [31:0]       ir_pc_q;
    logic              ir_valid_q;
    logic              sav_jump_q;
    logic [29:0]       sav_val_q;

    logic              req;
    logic              ack_acc;
    logic              xfer;
    logic [1:0]        ps_d;
    logic [29:0]       pc_in_d;

    always_comb begin
        req = 1'b0;
        if (reset) begin
            unique case (state_q)
                S_FETCH: req = !ir_valid_q;
                S_DRAIN: req = 1'b1;
                default: req = 1'b0;
            endcase
        end
    end

    // An ack with no request outstanding belongs to a read dropped by reset.
    assign ack_acc = req & bus.imem_ack;
    assign xfer    = ir_valid_q & bus.ir_ready;

    // PC controls are combinational so the PC moves on the same edge.
    always_comb begin
        ps_d    = PS_HOLD;
        pc_in_d = '0;
        if (reset) begin
            unique case (state_q)
                S_FETCH: begin
                    if (bus.redir_valid) begin
                        // With a read in flight the redirect is parked until it drains.
                        if (ack_acc || !req) begin
                            ps_d    = redir_ps(bus.redir_jump);
                            pc_in_d = bus.redir_val;
                        end
                    end else if (ack_acc) begin
                        ps_d = PS_INC;
                    end
                end
                S_DRAIN: begin
                    if (ack_acc) begin
                        // A redirect in the ack cycle is the newest one, so it wins.
                        if (bus.redir_valid) begin
                            ps_d    = redir_ps(bus.redir_jump);
                            pc_in_d = bus.redir_val;
                        end else begin
                            ps_d    = redir_ps(sav_jump_q);
                            pc_in_d = sav_val_q;
                        end
                    end
                end
                default: ps_d = PS_HOLD;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            sav_jump_q <= 1'b0;
            sav_val_q  <= '0;
        end else begin
            case (state_q)
                S_BOOT: state_q <= S_FETCH;
                S_FETCH: begin
                    if (bus.redir_valid) begin
                        // Squashes any same-cycle transfer to decode as well.
                        ir_valid_q <= 1'b0;
                        if (req && !bus.imem_ack) begin
                            sav_jump_q <= bus.redir_jump;
                            sav_val_q  <= bus.redir_val;
                            state_q    <= S_DRAIN;
                        end
                    end else if (ack_acc) begin
                        ir_q       <= bus.imem_rdata;
                        ir_pc_q    <= bus.pc_q;
                        ir_valid_q <= 1'b1;
                    end else if (xfer) begin
                        ir_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (bus.redir_valid) begin
                        sav_jump_q <= bus.redir_jump;
                        sav_val_q  <= bus.redir_val;
                    end
                    if (ack_acc) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    assign bus.ps        = ps_d;
    assign bus.pc_in     = pc_in_d;
    assign bus.imem_req  = req;
    assign bus.imem_addr = bus.pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic clock;
    logic reset;
    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int errors = 0;
    int checks = 0;

    logic ack_en;
    logic ack_force;

    // bench-side model state
    logic        m_live = 1'b0;
    logic        m_boot;
    logic        m_full;
    logic [31:0] m_ir_addr;
    logic        m_sq;
    logic        m_sj;
    logic [29:0] m_sv;
    logic        e_req;
    logic        ackv;
    logic [1:0]  e_ps;
    logic [29:0] e_pcin;
    logic        chk_pcin;
    logic [31:0] xfer_log[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // PC register: jump loads the word address, relative adds a word offset.
    always @(posedge clock) begin
        if (!reset) bus.pc_q <= PC_RESET_VALUE;
        else begin
            case (bus.ps)
                2'b01:   bus.pc_q <= bus.pc_q + 32'd4;
                2'b11:   bus.pc_q <= {bus.pc_in, 2'b00};
                2'b10:   bus.pc_q <= bus.pc_q + {bus.pc_in, 2'b00};
                default: bus.pc_q <= bus.pc_q;
            endcase
        end
    end

    // Instruction memory: acks in the cycle the request is seen when enabled.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clock);
            #2;
            if (ack_force || (ack_en && bus.imem_req)) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = '0;
            end
        end
    end

    // Compare process: per-cycle expectations from the fetch rules.
    initial forever begin
        @(negedge clock);
        if (m_live) begin
            chk("ir_valid", bus.ir_valid, m_full);
            if (m_full) begin
                chk("ir_pc", bus.ir_pc, m_ir_addr);
                chk("ir", bus.ir, mem_word(m_ir_addr));
            end
        end
        if (!reset) begin
            chk("req_in_reset", bus.imem_req, 1'b0);
            chk("ps_in_reset", bus.ps, 2'b00);
            m_live = 1'b1;
            m_boot = 1'b1;
            m_full = 1'b0;
            m_sq   = 1'b0;
        end else if (m_live) begin
            if (m_boot) begin
                chk("req_boot", bus.imem_req, 1'b0);
                chk("ps_boot", bus.ps, 2'b00);
                m_boot = 1'b0;
            end else begin
                e_req    = m_sq || !m_full;
                ackv     = bus.imem_ack && e_req;
                e_ps     = 2'b00;
                e_pcin   = '0;
                chk_pcin = 1'b0;
                chk("req", bus.imem_req, e_req);
                chk("imem_addr", bus.imem_addr, bus.pc_q);
                if (m_sq) begin
                    if (bus.redir_valid) begin
                        m_sj = bus.redir_jump;
                        m_sv = bus.redir_val;
                    end
                    if (ackv) begin
                        e_ps     = m_sj ? 2'b11 : 2'b10;
                        e_pcin   = m_sv;
                        chk_pcin = 1'b1;
                        m_sq     = 1'b0;
                    end
                end else if (bus.redir_valid) begin
                    m_full = 1'b0;
                    if (e_req && !ackv) begin
                        m_sq = 1'b1;
                        m_sj = bus.redir_jump;
                        m_sv = bus.redir_val;
                    end else begin
                        e_ps     = bus.redir_jump ? 2'b11 : 2'b10;
                        e_pcin   = bus.redir_val;
                        chk_pcin = 1'b1;
                    end
                end else if (ackv) begin
                    e_ps      = 2'b01;
                    m_full    = 1'b1;
                    m_ir_addr = bus.pc_q;
                end else if (m_full && bus.ir_ready) begin
                    xfer_log.push_back(m_ir_addr);
                    m_full = 1'b0;
                end
                chk("ps", bus.ps, e_ps);
                if (chk_pcin) chk("pc_in", bus.pc_in, e_pcin);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_req_addr(input string name, input logic [31:0] exp);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.imem_req && n < 50);
        chk({name, "_req"}, bus.imem_req, 1'b1);
        chk(name, bus.imem_addr, exp);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.imem_req && n < 50);
        chk(name, bus.imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.ir_valid && n < 50);
        chk(name, bus.ir_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b0;
        bus.ir_ready    = 1'b1;
        bus.redir_valid = 1'b0;
        bus.redir_jump  = 1'b0;
        bus.redir_val   = '0;
        ack_en          = 1'b1;
        ack_force       = 1'b0;

        // boot and stream three instructions
        cyc(2);
        reset = 1'b1;
        cyc(7);
        bus.ir_ready = 1'b0;
        chk("boot_xfer_count", xfer_log.size(), 3);
        if (xfer_log.size() >= 3) begin
            chk("boot_xfer0", xfer_log[0], 32'h8000_0000);
            chk("boot_xfer1", xfer_log[1], 32'h8000_0004);
            chk("boot_xfer2", xfer_log[2], 32'h8000_0008);
        end

        // decode stalled: buffer holds, no request, PC holds
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_req", bus.imem_req, 1'b0);
            chk("stall_ps", bus.ps, 2'b00);
            chk("stall_ir_pc", bus.ir_pc, 32'h8000_000C);
            chk("stall_ir", bus.ir, mem_word(32'h8000_000C));
            chk("stall_pc_q", bus.pc_q, 32'h8000_0010);
        end

        // relative redirect of -1 word against an outstanding read
        cyc(1);
        bus.ir_ready = 1'b1;
        ack_en       = 1'b0;
        cyc(1);
        bus.redir_valid = 1'b1;
        bus.redir_jump  = 1'b0;
        bus.redir_val   = 30'h3FFF_FFFF;
        @(negedge clock);
        chk("rel_park_ps", bus.ps, 2'b00);
        chk("rel_park_addr", bus.imem_addr, 32'h8000_0010);
        cyc(1);
        bus.redir_valid = 1'b0;
        cyc(2);
        ack_en = 1'b1;
        @(negedge clock);
        chk("rel_ack_ps", bus.ps, 2'b10);
        chk("rel_ack_pc_in", bus.pc_in, 32'h3FFF_FFFF);
        cyc(1);
        wait_req_addr("rel_next_addr", 32'h8000_000C);
        chk("rel_dropped", bus.ir_valid, 1'b0);

        // jump while buffer full
        cyc(1);
        bus.ir_ready = 1'b0;
        wait_valid("jump_full_wait");
        cyc(1);
        bus.redir_valid = 1'b1;
        bus.redir_jump  = 1'b1;
        bus.redir_val   = 30'h0000_0100;
        @(negedge clock);
        chk("jump_ps", bus.ps, 2'b11);
        chk("jump_pc_in", bus.pc_in, 32'h0000_0100);
        chk("jump_req", bus.imem_req, 1'b0);
        cyc(1);
        bus.redir_valid = 1'b0;
        wait_req_addr("jump_next_addr", 32'h0000_0400);
        chk("jump_cleared", bus.ir_valid, 1'b0);

        // two redirects while draining: the second wins
        cyc(1);
        ack_en       = 1'b0;
        bus.ir_ready = 1'b1;
        wait_req("drain_wait");
        cyc(1);
        bus.redir_valid = 1'b1;
        bus.redir_jump  = 1'b1;
        bus.redir_val   = 30'h10;
        cyc(1);
        bus.redir_val   = 30'h20;
        cyc(1);
        bus.redir_valid = 1'b0;
        cyc(1);
        ack_en = 1'b1;
        @(negedge clock);
        chk("drain_ps", bus.ps, 2'b11);
        chk("drain_pc_in", bus.pc_in, 32'h20);
        cyc(1);
        wait_req_addr("drain_next_addr", 32'h0000_0080);

        // wrap at the top of the address space
        cyc(1);
        bus.redir_valid = 1'b1;
        bus.redir_jump  = 1'b1;
        bus.redir_val   = 30'h3FFF_FFFF;
        cyc(1);
        bus.redir_valid = 1'b0;
        wait_req_addr("wrap_top_addr", 32'hFFFF_FFFC);
        wait_req_addr("wrap_zero_addr", 32'h0000_0000);

        // reset with a read pending; ack lands during reset
        cyc(1);
        ack_en = 1'b0;
        wait_req("rst_pending_wait");
        cyc(1);
        reset     = 1'b0;
        ack_force = 1'b1;
        cyc(2);
        reset     = 1'b0;
        ack_force = 1'b0;
        reset     = 1'b1;
        ack_en    = 1'b1;
        @(negedge clock);
        chk("rst_boot_valid", bus.ir_valid, 1'b0);
        chk("rst_boot_req", bus.imem_req, 1'b0);
        wait_req_addr("rst_restart_addr", 32'h8000_0000);
        chk("rst_restart_valid", bus.ir_valid, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("rst_restart_xfer", xfer_log[$], 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
